// File: rtl/cpu_instr_queue.sv
// Fetch-to-decode instruction queue: owns the fetch PC, buffers {pc, instr}
// pairs in a power-of-two ring and presents the head to decode show-ahead.

`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif
`ifndef BOOT_ADDR
`define BOOT_ADDR 0
`endif

module cpu_instr_queue #(
    parameter int unsigned ADDR_WIDTH = `VIRTUAL_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(`BOOT_ADDR)
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        fetch_pc,
    input  logic [ADDR_WIDTH-1:0]        fetch_next_pc,
    input  logic                         fetch_hit,
    input  logic [31:0]                  fetch_instr,
    output logic                         fetch_stall,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        flush_pc,
    output logic                         dec_valid,
    output logic [31:0]                  dec_instr,
    output logic [ADDR_WIDTH-1:0]        dec_pc,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]           instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    logic full;
    logic pop;
    logic push;

    // Handshake decode; a pop frees a slot for a same-cycle push when full
    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        dec_valid   = (count_q != '0);
        pop         = dec_valid && dec_ready;
        push        = fetch_hit && !flush && (!full || pop);
        fetch_stall = full && !pop;
        dec_instr   = instr_mem[rd_ptr];
        dec_pc      = pc_mem[rd_ptr];
    end

    assign fetch_pc = pc_q;
    assign count    = count_q;

    // Control state: reset beats flush, flush beats push/pop
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            pc_q    <= flush_pc;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc_q   <= fetch_next_pc;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity lives in count/pointers
    always_ff @(posedge clock) begin
        if (reset && push) begin
            pc_mem[wr_ptr]    <= pc_q;
            instr_mem[wr_ptr] <= fetch_instr;
        end
    end

endmodule

// File: tb/tb_cpu_instr_queue.sv
// Directed bench for cpu_instr_queue: fill/stall, full push+pop, flush,
// single-entry latency, randomized ordering against a queue model, reset.

module tb_cpu_instr_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RPC = 32'h0000_1000;

    logic          clock;
    logic          reset;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] fetch_next_pc;
    logic          fetch_hit;
    logic [31:0]   fetch_instr;
    logic          fetch_stall;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          dec_valid;
    logic [31:0]   dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_ready;
    logic [2:0]    count;

    logic          use_auto;
    logic [31:0]   instr_sel;

    int checks;
    int errors;

    cpu_instr_queue #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .fetch_next_pc (fetch_next_pc),
        .fetch_hit     (fetch_hit),
        .fetch_instr   (fetch_instr),
        .fetch_stall   (fetch_stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fetch stage stand-in: sequential PCs, instruction tagged with its PC
    assign fetch_next_pc = fetch_pc + 32'd4;
    assign fetch_instr   = use_auto ? {16'hC0DE, fetch_pc[15:0]} : instr_sel;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic        mpush;
    logic        mpop;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        fetch_hit = 1'b1;
        flush     = 1'b1;
        flush_pc  = 32'h5000;
        dec_ready = 1'b1;
        use_auto  = 1'b1;
        instr_sel = 32'h0;

        // Reset overrides flush/push/pop
        tick();
        chk("rst_pc", 64'(fetch_pc), 64'(RPC));
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_stall", 64'(fetch_stall), 64'd0);
        tick();
        chk("rst_pc2", 64'(fetch_pc), 64'(RPC));

        // Fill with dec_ready low
        reset     = 1'b1;
        flush     = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("pre_push_valid", 64'(dec_valid), 64'd0);
        chk("pre_push_stall", 64'(fetch_stall), 64'd0);
        tick();
        chk("fill1_count", 64'(count), 64'd1);
        chk("fill1_dec_pc", 64'(dec_pc), 64'h1000);
        chk("fill1_dec_instr", 64'(dec_instr), 64'hC0DE1000);
        chk("fill1_fetch_pc", 64'(fetch_pc), 64'h1004);
        tick();
        tick();
        tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_stall", 64'(fetch_stall), 64'd1);
        chk("full_fetch_pc", 64'(fetch_pc), 64'h1010);
        tick();
        chk("hold_count", 64'(count), 64'd4);
        chk("hold_fetch_pc", 64'(fetch_pc), 64'h1010);
        chk("hold_dec_pc", 64'(dec_pc), 64'h1000);

        // Full with push and pop together
        dec_ready = 1'b1;
        #1;
        chk("full_pop_stall", 64'(fetch_stall), 64'd0);
        tick();
        chk("pp1_count", 64'(count), 64'd4);
        chk("pp1_dec_pc", 64'(dec_pc), 64'h1004);
        chk("pp1_fetch_pc", 64'(fetch_pc), 64'h1014);
        tick();
        chk("pp2_count", 64'(count), 64'd4);
        chk("pp2_dec_pc", 64'(dec_pc), 64'h1008);
        chk("pp2_fetch_pc", 64'(fetch_pc), 64'h1018);

        // Pop only; fetch_pc holds without a push
        fetch_hit = 1'b0;
        tick();
        chk("pop_count", 64'(count), 64'd3);
        chk("pop_dec_pc", 64'(dec_pc), 64'h100C);
        chk("pop_fetch_pc", 64'(fetch_pc), 64'h1018);

        // Back-to-back flushes; latest target wins, offered instr dropped
        fetch_hit = 1'b1;
        flush     = 1'b1;
        flush_pc  = 32'h2400;
        tick();
        chk("fl1_count", 64'(count), 64'd0);
        chk("fl1_valid", 64'(dec_valid), 64'd0);
        chk("fl1_fetch_pc", 64'(fetch_pc), 64'h2400);
        flush_pc = 32'h2000;
        tick();
        chk("fl2_fetch_pc", 64'(fetch_pc), 64'h2000);
        chk("fl2_count", 64'(count), 64'd0);
        flush     = 1'b0;
        dec_ready = 1'b0;
        tick();
        chk("postfl_count", 64'(count), 64'd1);
        chk("postfl_dec_pc", 64'(dec_pc), 64'h2000);
        chk("postfl_dec_instr", 64'(dec_instr), 64'hC0DE2000);

        // Drain, then dec_ready on empty queue must not underflow
        fetch_hit = 1'b0;
        dec_ready = 1'b1;
        tick();
        chk("drain_count", 64'(count), 64'd0);
        tick();
        chk("empty_rdy_count", 64'(count), 64'd0);
        chk("empty_rdy_valid", 64'(dec_valid), 64'd0);

        // Single push into empty queue: visible only after the edge
        use_auto  = 1'b0;
        instr_sel = 32'hDEADBEEF;
        fetch_hit = 1'b1;
        dec_ready = 1'b0;
        #1;
        chk("lat_before_valid", 64'(dec_valid), 64'd0);
        tick();
        chk("lat_after_valid", 64'(dec_valid), 64'd1);
        chk("lat_after_instr", 64'(dec_instr), 64'hDEADBEEF);
        chk("lat_after_pc", 64'(dec_pc), 64'h2004);
        // Push and pop at count == 1
        instr_sel = 32'hCAFEF00D;
        dec_ready = 1'b1;
        tick();
        chk("c1_pp_count", 64'(count), 64'd1);
        chk("c1_pp_instr", 64'(dec_instr), 64'hCAFEF00D);
        chk("c1_pp_pc", 64'(dec_pc), 64'h2008);
        fetch_hit = 1'b0;
        tick();
        chk("c1_pop_count", 64'(count), 64'd0);
        chk("rand_start_pc", 64'(fetch_pc), 64'h200C);

        // Random push/pop against a reference queue
        mpc = 32'h200C;
        for (int i = 0; i < 6 * DEPTH; i++) begin
            fetch_hit = ($urandom_range(0, 3) != 0);
            dec_ready = 1'($urandom_range(0, 1));
            instr_sel = $urandom;
            mpop  = (mq.size() != 0) && dec_ready;
            mpush = fetch_hit && ((mq.size() < DEPTH) || mpop);
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back({mpc, instr_sel});
                mpc = mpc + 32'd4;
            end
            tick();
            chk("rnd_count", 64'(count), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("rnd_dec_pc", 64'(dec_pc), 64'(mq[0][63:32]));
                chk("rnd_dec_instr", 64'(dec_instr), 64'(mq[0][31:0]));
            end else begin
                chk("rnd_valid", 64'(dec_valid), 64'd0);
            end
        end
        chk("rnd_fetch_pc", 64'(fetch_pc), 64'(mpc));

        // Reset with entries queued and flush asserted
        use_auto  = 1'b1;
        fetch_hit = 1'b0;
        dec_ready = 1'b0;
        flush     = 1'b1;
        flush_pc  = 32'h4000;
        tick();
        flush     = 1'b0;
        fetch_hit = 1'b1;
        tick();
        tick();
        chk("pre_rst_count", 64'(count), 64'd2);
        reset     = 1'b0;
        flush     = 1'b1;
        flush_pc  = 32'h7000;
        dec_ready = 1'b1;
        tick();
        chk("mid_rst_pc", 64'(fetch_pc), 64'(RPC));
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(dec_valid), 64'd0);
        reset     = 1'b1;
        flush     = 1'b0;
        dec_ready = 1'b0;
        tick();
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_dec_pc", 64'(dec_pc), 64'(RPC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
